// File: rtl/milano_pkg.sv
// Shared fetch-path types and constants.
package milano_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam logic [XLEN_DEFAULT-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries; head is read straight from the
// storage so a word pushed at an edge is visible right after that edge.
module fetch_fifo
  import milano_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fetch_entry_t wdata_i,
  output logic [CW-1:0] count_o,
  output fetch_entry_t head_o
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count alone decides which slots are live.
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && !clear_i && count_q == CW'(DEPTH)));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    !(pop_i && !clear_i && count_q == '0));

endmodule

// File: rtl/fetch_buffer.sv
// Fetch buffer: tracks the outstanding RAM request, pairs the returning word
// with its PC, queues it, and stalls prefetch before the queue can overflow.
module fetch_buffer
  import milano_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = XLEN_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            fetch_enable_i,
  input  logic [XLEN-1:0] instr_addr_i,
  input  logic [XLEN-1:0] instr_rdata_i,
  input  logic            flush_i,
  input  logic            id_ready_i,
  output logic            fetch_stall_o,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            empty_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic            req_pending_q, req_pending_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [CW-1:0]   count;
  logic            accept, push, pop;
  fetch_entry_t    push_entry, head_entry;

  // Counting the in-flight request keeps a slot reserved for its response;
  // a same-cycle pop deliberately does not release the stall.
  assign fetch_stall_o = ({1'b0, count} + (CW+1)'(req_pending_q)) >= (CW+1)'(DEPTH);
  assign instr_valid_o = (count != '0);
  assign empty_o       = ~instr_valid_o;

  always_comb begin
    accept        = fetch_enable_i & ~fetch_stall_o & ~flush_i;
    push          = req_pending_q & ~flush_i;
    pop           = instr_valid_o & id_ready_i & ~flush_i;
    req_pending_d = accept;
    req_pc_d      = accept ? instr_addr_i : req_pc_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_pending_q <= 1'b0;
      req_pc_q      <= '0;
    end else begin
      req_pending_q <= req_pending_d;
      req_pc_q      <= req_pc_d;
    end
  end

  assign push_entry = '{pc: req_pc_q, instr: instr_rdata_i};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_entry),
    .count_o (count),
    .head_o  (head_entry)
  );

  assign instr_o = instr_valid_o ? head_entry.instr : NOP_INSTR;
  assign pc_o    = instr_valid_o ? head_entry.pc    : '0;

  a_rdata_known: assert property (@(posedge clk_i) disable iff (rst_i)
    push |-> !$isunknown(instr_rdata_i));

endmodule
